// File: rtl/draw_cmd_gen.sv
// Turns a debounced push-button press into a single draw command (start_sig + radius r)
// for a circle drawer, handshaking on draw_busy with an acknowledge timeout.
module draw_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned R_W             = 6,
    parameter int unsigned R_MIN           = 1,
    parameter int unsigned ACK_TIMEOUT     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_raw,
    input  logic [R_W-1:0] sw_raw,
    input  logic           draw_busy,
    output logic           start_sig,
    output logic [R_W-1:0] r,
    output logic           cmd_pending,
    output logic           btn_level
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [R_W-1:0]  R_MIN_V = R_W'(R_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PENDING,
        S_ISSUE,
        S_WAIT_ACK,
        S_BUSY
    } state_t;

    logic            r_btn_s1;
    logic            r_btn_s2;
    logic [R_W-1:0]  r_sw_s1;
    logic [R_W-1:0]  r_sw_s2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn_level;
    logic            r_btn_level_q;

    state_t          r_state;
    logic [TO_W-1:0] r_to_cnt;
    logic [R_W-1:0]  r_pend;
    logic [R_W-1:0]  r_r;
    logic            r_start;
    logic            r_cmd_pending;

    logic            w_press;
    logic [R_W-1:0]  w_sw_clamped;
    logic [R_W-1:0]  w_pend_nxt;
    state_t          w_state_nxt;
    logic            w_latch;
    logic [TO_W-1:0] w_to_nxt;
    logic            w_start_nxt;
    logic            w_pending_nxt;
    logic            w_load_r;

    // Input synchronizers and button debouncer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_s1      <= 1'b0;
            r_btn_s2      <= 1'b0;
            r_sw_s1       <= '0;
            r_sw_s2       <= '0;
            r_db_cnt      <= '0;
            r_btn_level   <= 1'b0;
            r_btn_level_q <= 1'b0;
        end else begin
            r_btn_s1      <= btn_raw;
            r_btn_s2      <= r_btn_s1;
            r_sw_s1       <= sw_raw;
            r_sw_s2       <= r_sw_s1;
            r_btn_level_q <= r_btn_level;
            if (r_btn_s2 == r_btn_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt    <= '0;
                r_btn_level <= ~r_btn_level;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Press = the cycle the debounced level is first seen high; releases are ignored
    assign w_press      = r_btn_level & ~r_btn_level_q;
    assign w_sw_clamped = (r_sw_s2 < R_MIN_V) ? R_MIN_V : r_sw_s2;
    assign w_pend_nxt   = w_latch ? w_sw_clamped : r_pend;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_to_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_latch     = 1'b1;
                    w_state_nxt = draw_busy ? S_PENDING : S_ISSUE;
                end
            end
            S_PENDING: begin
                w_latch = w_press;
                if (!draw_busy) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (draw_busy) begin
                    w_state_nxt = S_BUSY;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_BUSY: begin
                if (!draw_busy) begin
                    w_state_nxt = S_IDLE;
                end else if (w_press) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_PENDING;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_start_nxt   = (w_state_nxt == S_ISSUE);
        w_load_r      = (w_state_nxt == S_ISSUE) && (r_state != S_ISSUE);
        w_pending_nxt = (w_state_nxt == S_PENDING) || (w_state_nxt == S_ISSUE)
                     || (w_state_nxt == S_WAIT_ACK);
    end

    // State register; r only loads on entry to ISSUE so it holds between commands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_to_cnt      <= '0;
            r_pend        <= R_MIN_V;
            r_r           <= R_MIN_V;
            r_start       <= 1'b0;
            r_cmd_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_to_cnt      <= w_to_nxt;
            r_pend        <= w_pend_nxt;
            r_start       <= w_start_nxt;
            r_cmd_pending <= w_pending_nxt;
            if (w_load_r) begin
                r_r <= w_pend_nxt;
            end
        end
    end

    assign start_sig   = r_start;
    assign r           = r_r;
    assign cmd_pending = r_cmd_pending;
    assign btn_level   = r_btn_level;

endmodule

// File: tb/tb_draw_cmd_gen.sv
// Bench for draw_cmd_gen: directed table of clean presses, hand-written corner sequences,
// and a randomized run checked cycle-by-cycle against a behavioural model.
module tb_draw_cmd_gen;

    localparam int unsigned DB   = 4;
    localparam int unsigned RW   = 6;
    localparam int unsigned RMIN = 1;
    localparam int unsigned ACKT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_raw;
    logic [RW-1:0] sw_raw;
    logic          draw_busy;
    logic          start_sig;
    logic [RW-1:0] r;
    logic          cmd_pending;
    logic          btn_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    draw_cmd_gen #(
        .DEBOUNCE_CYCLES(DB),
        .R_W(RW),
        .R_MIN(RMIN),
        .ACK_TIMEOUT(ACKT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .sw_raw(sw_raw),
        .draw_busy(draw_busy),
        .start_sig(start_sig),
        .r(r),
        .cmd_pending(cmd_pending),
        .btn_level(btn_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until start_sig is seen; lat = -1 if the budget runs out
    task automatic wait_start(input int budget, output int lat, output logic [RW-1:0] rv);
        lat = -1;
        rv  = '0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (start_sig) begin
                lat = i;
                rv  = r;
                break;
            end
        end
    endtask

    // Behavioural model: a request flag, an ack window countdown and a "drawer busy with ours" flag
    logic          m_s1, m_s2, m_lvl, m_lvl_q;
    int            m_run;
    logic [RW-1:0] m_sw1, m_sw2, m_pend, m_r;
    logic          m_want, m_issue, m_drawing;
    int            m_ack_left;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl_q = 0; m_run = 0;
        m_sw1 = '0; m_sw2 = '0; m_pend = RW'(RMIN); m_r = RW'(RMIN);
        m_want = 0; m_issue = 0; m_drawing = 0; m_ack_left = 0;
    endtask

    task automatic model_step(input logic b, input logic [RW-1:0] sw, input logic busy);
        logic          press;
        logic [RW-1:0] cl;
        press = m_lvl && !m_lvl_q;
        cl    = (int'(m_sw2) < int'(RMIN)) ? RW'(RMIN) : m_sw2;
        if (m_issue) begin
            m_issue    = 0;
            m_ack_left = ACKT;
        end else if (m_ack_left > 0) begin
            if (busy) begin
                m_ack_left = 0;
                m_drawing  = 1;
            end else begin
                m_ack_left--;
            end
        end else if (m_drawing) begin
            if (!busy) m_drawing = 0;
            else if (press) begin
                m_pend = cl; m_want = 1; m_drawing = 0;
            end
        end else begin
            if (press) begin
                m_pend = cl; m_want = 1;
            end
            if (m_want && !busy) begin
                m_want = 0; m_issue = 1; m_r = m_pend;
            end
        end
        m_lvl_q = m_lvl;
        if (m_s2 == m_lvl) m_run = 0;
        else if (m_run == int'(DB) - 1) begin
            m_run = 0; m_lvl = ~m_lvl;
        end else m_run++;
        m_s2 = m_s1; m_s1 = b;
        m_sw2 = m_sw1; m_sw1 = sw;
    endtask

    typedef struct {
        logic [RW-1:0] sw;
        logic [RW-1:0] exp_r;
        int            exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        int            pulses;
        int            lvl_hi;
        logic [RW-1:0] rv;

        vecs[0] = '{6'd20, 6'd20, 7};
        vecs[1] = '{6'd0,  6'd1,  7};
        vecs[2] = '{6'd63, 6'd63, 7};
        vecs[3] = '{6'd1,  6'd1,  7};
        vecs[4] = '{6'd2,  6'd2,  7};

        rst = 1; btn_raw = 0; sw_raw = '0; draw_busy = 0;
        tick();
        check("reset_r_during", 32'(r), 32'(RMIN));
        repeat (2) tick();
        rst = 0;
        check("reset_start", 32'(start_sig), 0);
        check("reset_pending", 32'(cmd_pending), 0);
        check("reset_level", 32'(btn_level), 0);

        // Clean presses with the drawer never acknowledging
        for (int i = 0; i < 5; i++) begin
            sw_raw = vecs[i].sw; draw_busy = 0; btn_raw = 1;
            wait_start(20, lat, rv);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_r", i), 32'(rv), 32'(vecs[i].exp_r));
            check($sformatf("vec%0d_pending_issue", i), 32'(cmd_pending), 1);
            tick();
            btn_raw = 0;
            check($sformatf("vec%0d_single_pulse", i), 32'(start_sig), 0);
            repeat (15) tick();
            check($sformatf("vec%0d_pending_last_wait", i), 32'(cmd_pending), 1);
            tick();
            check($sformatf("vec%0d_timeout_idle", i), 32'(cmd_pending), 0);
            check($sformatf("vec%0d_r_held", i), 32'(r), 32'(vecs[i].exp_r));
            repeat (4) tick();
        end

        // Bouncing button: no command while bouncing, exactly one after it settles
        sw_raw = 6'd37; pulses = 0; lvl_hi = 0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i / 2) % 2 == 0);
            tick();
            if (start_sig) pulses++;
            if (btn_level) lvl_hi++;
        end
        check("bounce_no_start", 32'(pulses), 0);
        check("bounce_level_low", 32'(lvl_hi), 0);
        btn_raw = 1; pulses = 0; rv = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (start_sig) begin
                pulses++; rv = r;
            end
        end
        check("bounce_one_pulse", 32'(pulses), 1);
        check("bounce_r", 32'(rv), 37);
        btn_raw = 0;
        repeat (10) tick();

        // Two presses while the drawer is busy: last press wins, single command
        draw_busy = 1; sw_raw = 6'd10; btn_raw = 1;
        repeat (10) tick();
        check("busy_pending", 32'(cmd_pending), 1);
        check("busy_no_start", 32'(start_sig), 0);
        btn_raw = 0;
        repeat (10) tick();
        sw_raw = 6'd30; btn_raw = 1;
        repeat (10) tick();
        btn_raw = 0;
        repeat (10) tick();
        check("busy_still_pending", 32'(cmd_pending), 1);
        draw_busy = 0;
        tick();
        check("busy_release_start", 32'(start_sig), 1);
        check("busy_release_r", 32'(r), 30);
        draw_busy = 1;
        repeat (3) tick();
        check("busy_ack_pending", 32'(cmd_pending), 0);
        draw_busy = 0; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (start_sig) pulses++;
        end
        check("busy_no_extra_pulse", 32'(pulses), 0);

        // Reset while PENDING abandons the command
        draw_busy = 1; sw_raw = 6'd5; btn_raw = 1;
        repeat (10) tick();
        check("rstpend_pending", 32'(cmd_pending), 1);
        btn_raw = 0; rst = 1;
        tick();
        check("rstpend_start", 32'(start_sig), 0);
        check("rstpend_r", 32'(r), 32'(RMIN));
        check("rstpend_pending_clr", 32'(cmd_pending), 0);
        check("rstpend_level", 32'(btn_level), 0);
        rst = 0; draw_busy = 0; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (start_sig) pulses++;
        end
        check("rstpend_no_start", 32'(pulses), 0);

        // Button held through reset release yields one command
        btn_raw = 1; sw_raw = 6'd44; rst = 1;
        repeat (3) tick();
        rst = 0;
        wait_start(20, lat, rv);
        check("heldrst_latency", 32'(lat), 32'(DB + 3));
        check("heldrst_r", 32'(rv), 44);
        btn_raw = 0;
        repeat (25) tick();

        // Randomized run against the behavioural model
        rst = 1; btn_raw = 0; draw_busy = 0; sw_raw = '0;
        repeat (2) tick();
        rst = 0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9, 0) == 0) btn_raw = ~btn_raw;
            if ($urandom_range(7, 0) == 0) draw_busy = ~draw_busy;
            sw_raw = RW'($urandom_range(63, 0));
            tick();
            model_step(btn_raw, sw_raw, draw_busy);
            check($sformatf("rand_c%0d{start,pend,lvl,r}", c),
                  {23'd0, start_sig, cmd_pending, btn_level, r},
                  {23'd0, m_issue, (m_want || m_issue || m_ack_left > 0), m_lvl, m_r});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
